// File: rtl/demux4_nbit_reg.sv
// 1-to-4 registered demultiplexer with a one-word slot per output.
// Define DEMUX4_NBIT_REG_XFER_COUNT_EN to add the xfer_count port.
module demux4_nbit_reg #(
   parameter int DemuxWidth = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            select,
   input  logic [DemuxWidth-1:0] demux_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DemuxWidth-1:0] demux_out_1,
   output logic [DemuxWidth-1:0] demux_out_2,
   output logic [DemuxWidth-1:0] demux_out_3,
   output logic [DemuxWidth-1:0] demux_out_4,
   output logic                  out_valid_1,
   output logic                  out_valid_2,
   output logic                  out_valid_3,
   output logic                  out_valid_4,
   input  logic                  out_ready_1,
   input  logic                  out_ready_2,
   input  logic                  out_ready_3,
   input  logic                  out_ready_4
`ifdef DEMUX4_NBIT_REG_XFER_COUNT_EN
   ,
   output logic [7:0]            xfer_count
`endif
);

   logic [3:0]                  oready;
   logic [3:0]                  vld_q;
   logic [3:0]                  sel_oh;
   logic [3:0]                  load;
   logic [3:0][DemuxWidth-1:0]  data_q;

   assign oready = {out_ready_4, out_ready_3,
                    out_ready_2, out_ready_1};

   always_comb begin
      sel_oh = '0;
      unique case (select)
         2'd0: sel_oh = 4'b0001;
         2'd1: sel_oh = 4'b0010;
         2'd2: sel_oh = 4'b0100;
         2'd3: sel_oh = 4'b1000;
      endcase
   end

   // Only the selected slot gates acceptance.
   assign in_ready = rst_n & |(sel_oh & (~vld_q | oready));
   assign load     = sel_oh & {4{in_valid & in_ready}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         data_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (load[i]) begin
               vld_q[i]  <= 1'b1;
               data_q[i] <= demux_in;
            end else if (oready[i]) begin
               vld_q[i]  <= 1'b0;
            end
         end
      end
   end

   assign demux_out_1 = data_q[0];
   assign demux_out_2 = data_q[1];
   assign demux_out_3 = data_q[2];
   assign demux_out_4 = data_q[3];
   assign out_valid_1 = vld_q[0];
   assign out_valid_2 = vld_q[1];
   assign out_valid_3 = vld_q[2];
   assign out_valid_4 = vld_q[3];

`ifdef DEMUX4_NBIT_REG_XFER_COUNT_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (|load) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign xfer_count = cnt_q;
`endif

endmodule
